grid_video_gen: RTL
===================

// Module: grid_video_gen
// PURPOSE
//  Pipelined pixel-colour generator for an NxN board drawn on the 640x480 VGA raster.
//  Holds a per-cell 2-bit state memory and a blinking selection cursor latched once per frame.
//  Adds a board-clear sequencer and write port.
//  Sits between the VGA timing controller (x, y, active, frame_start) and the DAC pins (r, g, b).
// PARAMETERS
//  GRID_N       8    cells per side; CW = $clog2(GRID_N)
//  CELL_LOG2    5    cell edge = 2**CELL_LOG2 pixels (32)
//  ORIGIN_X     192  x of board's left edge
//  ORIGIN_Y     112  y of board's top edge
//  BLINK_FRAMES 30   frames per cursor on/off half-period; must be >= 1
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  x            in   10  current pixel column
//  y            in   10  current pixel row
//  active       in   1   raster inside visible area
//  frame_start  in   1   one-cycle pulse, first cycle of vertical blank
//  sel_x        in   CW  requested cursor column
//  sel_y        in   CW  requested cursor row
//  sel_valid    in   1   cursor enabled
//  wr_en        in   1   write cell state
//  wr_x         in   CW  write column
//  wr_y         in   CW  write row
//  wr_state     in   2   new cell state
//  clr          in   1   one-cycle pulse, start board clear
//  busy         out  1   clear in progress
//  r, g, b      out  8   registered pixel colour, each 8 bits
// BEHAVIOUR
//  Reset:
//   - r/g/b = 0, busy = 0, FSM = IDLE.
//   - Blink counter = 0, cursor_on = 1, latched sel = 0/0, latched valid = 0.
//   - Cell memory is NOT reset by rst_n; clr sets it to 0.
//  Pipeline (latency 2 clk from x/y/active to r/g/b):
//   - S1 registers:
//     - in_grid: dx = x-ORIGIN_X and dy = y-ORIGIN_Y both in [0, GRID_N<<CELL_LOG2).
//     - cell_x = dx>>CELL_LOG2, cell_y = dy>>CELL_LOG2.
//     - on_line: dx or dy low CELL_LOG2 bits == 0.
//     - active.
//   - Cell memory is read synchronously in S1.
//   - S2 registers r/g/b.
//  Colour priority in S2, highest first:
//   1. !active             -> 00 00 00
//   2. !in_grid            -> ff ff ff
//   3. on_line             -> 00 00 00
//   4. cursor hit          -> ff 00 00
//      - cursor hit = latched valid & cursor_on & cell == latched sel
//   5. cell state palette:
//      - 0 -> 22 a2 9c
//      - 1 -> 00 00 ff
//      - 2 -> ff d7 00
//      - 3 -> 00 c0 00
//  Frame sync:
//   - On frame_start, sel_x/sel_y/sel_valid are latched. Mid-frame changes never tear.
//   - Blink counter increments on frame_start.
//   - When it reaches BLINK_FRAMES-1 it wraps to 0 and cursor_on toggles.
//   - Latching sel_valid 0->1 forces cursor_on = 1 and counter = 0.
//  Writes:
//   - wr_en with wr_x < GRID_N and wr_y < GRID_N writes wr_state at the next edge.
//   - Out-of-range writes are ignored.
//   - A same-cycle read of the same cell returns the old value (read-before-write).
//  Clear FSM:
//   - IDLE: on clr -> CLEAR, with addr = 0 and busy = 1 from the next cycle.
//   - CLEAR: writes 0 to cell addr each cycle.
//     - At addr = GRID_N*GRID_N-1 -> IDLE, with busy = 0 the following cycle.
//     - The clear takes GRID_N*GRID_N cycles.
//   - While busy, wr_en is ignored and clr re-pulses are ignored (no restart).
//   - Display continues during a clear and may show a partly cleared board.
//   - rst_n low mid-clear aborts the clear: IDLE, busy = 0, memory contents undefined.
//  Simultaneous events: clr and wr_en in the same IDLE cycle -> clear wins and the write is dropped.
// TESTING
//  1. Reset, then raster (x=0, y=0, active=1):
//     - 2 clk later r/g/b = ff ff ff.
//     - With active=0 -> 00 00 00.
//  2. wr (3,2,state 1), then x=ORIGIN_X+3*32+5, y=ORIGIN_Y+2*32+5:
//     - 2 clk later 00 00 ff.
//     - At dx=96 (line) -> 00 00 00.
//  3. sel=(3,2), sel_valid=1, one frame_start, then scan cell (3,2):
//     - ff 00 00 for BLINK_FRAMES frames, then 00 00 ff for the next BLINK_FRAMES.
//     - A mid-frame sel change has no effect until the next frame_start.
//  4. Fill all cells with 2, then pulse clr:
//     - busy is high for exactly 64 cycles.
//     - A wr_en during busy is dropped.
//     - Every cell afterwards reads palette 0 (22 a2 9c).
//  5. Drive rst_n low 10 cycles into a clear:
//     - busy = 0 and r/g/b = 0 asynchronously.
//     - A fresh clr then completes in 64 cycles.
//  6. wr_x = GRID_N-1+1 (e.g. 8 when GRID_N=8 is illegal with CW=3):
//     - Run with GRID_N=6 and wr_x=7 -> no cell changes.
//     - Scan shows dx >= 192 as outside the grid (ff ff ff).

Source files
------------

// File: rtl/grid_video_gen.sv
// Pixel colour pipeline for an NxN board on a 640x480 raster: per-cell state memory,
// frame-latched blinking cursor, and a sequencer that clears the board one cell per cycle.
module grid_video_gen #(
  parameter int GRID_N       = 8,
  parameter int CELL_LOG2    = 5,
  parameter int ORIGIN_X     = 192,
  parameter int ORIGIN_Y     = 112,
  parameter int BLINK_FRAMES = 30,
  localparam int CW          = $clog2(GRID_N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          active,
  input  logic          frame_start,
  input  logic [CW-1:0] sel_x,
  input  logic [CW-1:0] sel_y,
  input  logic          sel_valid,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_x,
  input  logic [CW-1:0] wr_y,
  input  logic [1:0]    wr_state,
  input  logic          clr,
  output logic          busy,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b
);
  localparam int NCELL = GRID_N * GRID_N;
  localparam int AW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int BW    = $clog2(BLINK_FRAMES + 1);
  localparam logic [10:0] GRID_W = 11'(GRID_N << CELL_LOG2);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    mem [NCELL];

  // S1 decode; 11-bit subtraction so pixels left/above the board wrap to huge values
  logic [10:0]   dx, dy;
  logic          in_grid_d, on_line_d;
  logic [CW-1:0] cx_d, cy_d;
  logic [AW-1:0] rd_addr;

  assign dx        = {1'b0, x} - 11'(ORIGIN_X);
  assign dy        = {1'b0, y} - 11'(ORIGIN_Y);
  assign in_grid_d = (dx < GRID_W) && (dy < GRID_W);
  assign cx_d      = dx[CELL_LOG2 +: CW];
  assign cy_d      = dy[CELL_LOG2 +: CW];
  assign on_line_d = (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);
  assign rd_addr   = in_grid_d ? AW'(int'(cy_d) * GRID_N + int'(cx_d)) : '0;

  // Write port: the clear sequencer owns the memory while busy; a clr pulse drops a same-cycle write
  logic          wr_ok, we;
  logic [AW-1:0] wa;
  logic [1:0]    wd;

  assign wr_ok = wr_en && (int'(wr_x) < GRID_N) && (int'(wr_y) < GRID_N) &&
                 (state_q == IDLE) && !clr;

  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    if (state_q == CLEAR) begin
      we = 1'b1;
      wa = addr_q;
    end else if (wr_ok) begin
      we = 1'b1;
      wa = AW'(int'(wr_y) * GRID_N + int'(wr_x));
      wd = wr_state;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (clr) begin
        state_d = CLEAR;
        addr_d  = '0;
      end
      CLEAR: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == AW'(NCELL - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign busy = (state_q == CLEAR);

  // Cursor state only moves on frame_start so a frame is never drawn with two selections
  logic [CW-1:0] selx_q, sely_q;
  logic          selv_q, cur_on_q;
  logic [BW-1:0] blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selx_q   <= '0;
      sely_q   <= '0;
      selv_q   <= 1'b0;
      cur_on_q <= 1'b1;
      blink_q  <= '0;
    end else if (frame_start) begin
      selx_q <= sel_x;
      sely_q <= sel_y;
      selv_q <= sel_valid;
      if (sel_valid && !selv_q) begin
        blink_q  <= '0;
        cur_on_q <= 1'b1;
      end else if (blink_q == BW'(BLINK_FRAMES - 1)) begin
        blink_q  <= '0;
        cur_on_q <= !cur_on_q;
      end else begin
        blink_q <= blink_q + 1'b1;
      end
    end
  end

  logic          act_q, in_grid_q, on_line_q;
  logic [CW-1:0] cx_q, cy_q;
  logic [1:0]    cell_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= 1'b0;
      in_grid_q <= 1'b0;
      on_line_q <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      cell_q    <= '0;
    end else begin
      act_q     <= active;
      in_grid_q <= in_grid_d;
      on_line_q <= on_line_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      cell_q    <= mem[rd_addr];
    end
  end

  logic        hit;
  logic [23:0] rgb_d, rgb_q;

  assign hit = selv_q && cur_on_q && (cx_q == selx_q) && (cy_q == sely_q);

  always_comb begin
    rgb_d = 24'h000000;
    if (!act_q)          rgb_d = 24'h000000;
    else if (!in_grid_q) rgb_d = 24'hffffff;
    else if (on_line_q)  rgb_d = 24'h000000;
    else if (hit)        rgb_d = 24'hff0000;
    else begin
      case (cell_q)
        2'd0:    rgb_d = 24'h22a29c;
        2'd1:    rgb_d = 24'h0000ff;
        2'd2:    rgb_d = 24'hffd700;
        default: rgb_d = 24'h00c000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign r = rgb_q[23:16];
  assign g = rgb_q[15:8];
  assign b = rgb_q[7:0];
endmodule
